bcd_down_timer: RTL
===================

# bcd_down_timer

Loadable multi-digit BCD down-counter with a start/stop/done handshake; the counting-down counterpart of the team's mod-10 up-counter with carry-out. Each digit wraps 0→9 and borrows from the next digit up. A prescaler sets the decrement rate. The block stops at zero and pulses `done`, so it serves as a programmable decimal countdown timer next to the up-counting cells.

## Interface
- `DIGITS`, default 4: number of BCD digits; must be ≥ 1.
- `PRESCALE`, default 1: `clk` cycles per decrement; must be ≥ 1. Prescaler register width is max(1, $clog2(PRESCALE)).

Ports:
- `clk`  in  1: clock, rising edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `load`  in  1: load request, sampled only in IDLE.
- `load_val`  in  4*DIGITS: BCD value to load; digit i is `[4i+3:4i]`.
- `start`  in  1: start or resume countdown, sampled only in IDLE.
- `stop`  in  1: pause countdown, sampled only in RUN.
- `cnt`  out  4*DIGITS: current BCD count, registered.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse when the count reaches zero, or on a start issued at zero.
- `err`  out  1: one-cycle pulse when a load is rejected.

## Operation
- Reset (async assert, sync release): state IDLE, `cnt` = 0, prescaler = 0, `busy` = 0, `done` = 0, `err` = 0.
- **States:** IDLE, RUN, DONE.

**IDLE**
- `load` = 1:
  - If every digit of `load_val` is ≤ 9, `cnt` ← `load_val`.
  - Otherwise `cnt` is unchanged and `err` = 1 for the next cycle.
- `load` has priority over `start` in the same cycle; `start` is ignored in that cycle.
- `start` = 1 with `load` = 0:
  - `cnt` = 0 → go to DONE.
  - `cnt` ≠ 0 → go to RUN and clear the prescaler.
- `stop` is ignored.

**RUN**
- The prescaler counts 0 to PRESCALE-1. A tick occurs on the edge where the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
- On a tick, `cnt` decrements by one in BCD:
  - digit 0 decrements;
  - a digit at 0 becomes 9 and borrows from the next digit;
  - the borrow ripples within the same cycle.
- If the post-tick value is 0, go to DONE on the same edge.
- `stop` = 1: go to IDLE. `cnt` and the prescaler are frozen with no tick, even if a tick would have occurred that edge. The next `start` resumes with the prescaler cleared.
- `load` and `start` are ignored; `err` is not raised.

**DONE**
- `done` = 1 for exactly one cycle; `busy` = 0; next state is IDLE. All inputs are ignored.

**Arithmetic rules**
- Never decrement below zero; there is no 0 → 99..9 wrap at the top level.
- `cnt` is always valid BCD.

## Timing
- `busy` is a registered decode of state; it rises in the cycle after the `start` edge.
- Load at value V with PRESCALE = P: RUN lasts exactly V·P cycles. `done` is high in the cycle after the final tick edge, and `busy` is low in that same cycle.
- `start` at `cnt` = 0: `done` is high the cycle after the `start` edge; `busy` never rises.
- `err` is high the cycle after the rejecting `load` edge.
- `cnt` changes only on a tick edge or an accepted load edge.
- Reset asserted mid-RUN: all outputs go to their reset values immediately (async). No `done` is generated. After release the block is in IDLE with `cnt` = 0.

## Test plan
- **Basic countdown** (DIGITS=4, PRESCALE=1): load 16'h0012, start → `cnt` steps 0012, 0011, 0010, 0009 … 0000 on consecutive cycles. `busy` stays high for 12 cycles, then `done` is high for 1 cycle and `busy` = 0.
- **Borrow chain:** load 16'h1000, start → next values 0999, 0998. With load 16'h0100, the first tick gives 0099.
- **Invalid load:** load 16'h00A5 while `cnt` = 0042 → `err` = 1 for one cycle, `cnt` stays 0042. Also check load and start together with 16'h0003: `cnt` = 0003, state stays IDLE, `busy` = 0.
- **Pause and resume** (PRESCALE=3): load 0005, start, assert `stop` on the 2nd tick edge → `cnt` holds 0004 and `busy` = 0. Start again → ticks every 3 cycles; `done` comes 12 cycles after resume.
- **Start at zero:** with `cnt` = 0000, pulse `start` → `done` = 1 on the next cycle, `busy` stays 0, `cnt` stays 0000.
- **Reset mid-run:** load 0050, start, assert `rstn` low at `cnt` = 0037 → `cnt` = 0, `busy` = 0, `done` = 0 immediately. After release, `start` gives `done` on the next cycle.

Source files
------------

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer with prescaled decrement,
// start/stop control and a one-cycle done pulse when it reaches zero.
module bcd_down_timer #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  // Handshake: load/start are sampled only in IDLE (load wins), stop only
  // in RUN; done and err are single-cycle registered pulses.

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [W-1:0]  cnt_nx, cnt_dec;
  logic          err_nx, load_ok, tick, cnt_zero, dec_zero, borrow;

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Ripple borrow: trailing zero digits become 9 until a nonzero digit absorbs it.
  always_comb begin
    cnt_dec = cnt;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (cnt[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = 4'd9;
        end else begin
          cnt_dec[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  assign cnt_zero = (cnt == '0);
  assign dec_zero = (cnt_dec == '0);
  assign tick     = (state == S_RUN) && !stop && (presc == PRE_MAX) && !cnt_zero;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (!load && start) state_nx = cnt_zero ? S_DONE : S_RUN;
      S_RUN: begin
        if (stop)                 state_nx = S_IDLE;
        else if (tick && dec_zero) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_nx   = cnt;
    presc_nx = presc;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          if (load_ok) cnt_nx = load_val;
          else         err_nx = 1'b1;
        end else if (start) begin
          presc_nx = '0;
        end
      end
      S_RUN: begin
        // A stop freezes both count and prescaler, even on a tick edge.
        if (!stop) begin
          presc_nx = (presc == PRE_MAX) ? '0 : presc + PW'(1);
          if (tick) cnt_nx = cnt_dec;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      presc <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      cnt   <= cnt_nx;
      presc <= presc_nx;
      busy  <= (state_nx == S_RUN);
      done  <= (state_nx == S_DONE);
      err   <= err_nx;
    end
  end

  assign state_dbg = state;

endmodule
